serial_add_ctrl: RTL

- Bit-serial multi-bit adder controller. It time-shares one full-add resource, built from two halfadd instances plus an OR on the carries, across WIDTH bit positions, one bit per clock.
- Accepts operands with a start/ready handshake, sequences LSB-first and presents sum/cout with a one-cycle done pulse.
- Sits between operand registers and the result consumer in the lab datapath exercises.

---
 rtl/serial_add_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_ctrl
//  Brief    : Bit-serial WIDTH-bit adder controller. One full-add resource
//             (two halfadd cells plus an OR on the carries) is time-shared
//             across the bit positions, LSB first, one bit per clock.
//  Revision : 1.0  initial release
// ============================================================================

// Single-bit half adder: the building block of the shared full-add resource.
module halfadd (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RUN  = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         w_state_next;
   logic [WIDTH-1:0]   r_a;        // operand A, shifted right so bit 0 is current
   logic [WIDTH-1:0]   r_b;        // operand B, shifted right so bit 0 is current
   logic               r_carry;    // running carry between bit positions
   logic [WIDTH-1:0]   r_acc;      // partial result, filled MSB-side by shift-in
   logic [c_CNT_W-1:0] r_cnt;      // index of the bit being processed
   logic [WIDTH-1:0]   r_sum;      // published result, only updated on the last bit
   logic               r_cout;

   logic               w_p;        // propagate from first half adder
   logic               w_g0;       // generate from first half adder
   logic               w_g1;       // carry from second half adder
   logic               w_s;
   logic               w_cout;
   logic [WIDTH-1:0]   w_acc_next;
   logic               w_last;

   // Shared full-add resource: two half adders plus an OR on their carries.
   halfadd u_ha0 (.a(r_a[0]), .b(r_b[0]),  .s(w_p), .c(w_g0));
   halfadd u_ha1 (.a(w_p),    .b(r_carry), .s(w_s), .c(w_g1));

   assign w_cout     = w_g0 | w_g1;
   assign w_acc_next = {w_s, r_acc[WIDTH-1:1]};
   assign w_last     = (r_cnt == c_LAST);

   // State register; reset takes priority over any start request.
   always_ff @(posedge clk) begin
      if (rst) r_state <= c_IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the last bit, DONE -> IDLE.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_IDLE:  if (start)  w_state_next = c_RUN;
         c_RUN:   if (w_last) w_state_next = c_DONE;
         c_DONE:  w_state_next = c_IDLE;
         default: w_state_next = c_IDLE;
      endcase
   end

   // Handshake outputs decoded directly from the state.
   always_comb begin
      ready = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      case (r_state)
         c_IDLE:  ready = 1'b1;
         c_RUN:   busy  = 1'b1;
         c_DONE:  done  = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   // Datapath: latch operands on acceptance, then one bit per clock; the
   // visible result is written only with the final bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= cin;
                  r_acc   <= '0;
                  r_cnt   <= '0;
               end
            end
            c_RUN: begin
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_carry <= w_cout;
               r_acc   <= w_acc_next;
               r_cnt   <= r_cnt + c_CNT_W'(1);
               if (w_last) begin
                  r_sum  <= w_acc_next;
                  r_cout <= w_cout;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;

endmodule
`default_nettype wire
